// File: rtl/hazard_if.sv
// Hazard-control bundle: ID/EX/MEM status toward the controller, barrier
// enables/flushes and perf counters back. master = pipeline side, slave = controller.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_idx;
  logic [4:0]       id_rs2_idx;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd_idx;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_rd_idx, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_rd_idx, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch squash, memory-wait
// freeze with timeout watchdog, post-reset purge, and stall/flush counters.
module hazard_controller #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEMWAIT, S_ERROR} state_t;

  state_t           r_state, w_next;
  logic [IW-1:0]    r_init_cnt;
  logic [WW-1:0]    r_wait_cnt, w_wait_nxt;
  logic             r_timeout, w_timeout_set;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use, w_mem_stall, w_run_rules, w_branch_fire, w_stall_cnt_en;
  logic w_pc_write, w_if_id_write, w_id_ex_write, w_ex_mem_write;
  logic w_if_id_flush, w_id_ex_flush;

  assign w_mem_stall = bus.mem_req && !bus.mem_ready;
  assign w_load_use  = bus.ex_mem_read && (bus.ex_rd_idx != 5'd0) &&
                       ((bus.id_uses_rs1 && (bus.id_rs1_idx == bus.ex_rd_idx)) ||
                        (bus.id_uses_rs2 && (bus.id_rs2_idx == bus.ex_rd_idx)));

  always_comb begin
    w_next         = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_run_rules    = 1'b0;
    w_branch_fire  = 1'b0;
    w_pc_write     = 1'b0;
    w_if_id_write  = 1'b0;
    w_id_ex_write  = 1'b0;
    w_ex_mem_write = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;

    case (r_state)
      S_INIT: begin
        // Clock the cleared control fields through barriers with no data reset.
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        if (r_init_cnt == IW'(INIT_CYCLES - 1)) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_mem_stall) begin
          w_next     = S_MEMWAIT;
          w_wait_nxt = WW'(1);
        end else begin
          w_run_rules = 1'b1;
        end
      end
      S_MEMWAIT: begin
        // mem_req is not looked at here: the frozen MEM stage still holds it.
        if (!bus.mem_ready) begin
          w_wait_nxt = r_wait_cnt + 1'b1;
          if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
            w_next        = S_ERROR;
            w_timeout_set = 1'b1;
          end
        end else begin
          w_run_rules = 1'b1;
          w_next      = S_RUN;
        end
      end
      default: ;
    endcase

    if (w_run_rules) begin
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_id_ex_write  = 1'b1;
      w_ex_mem_write = 1'b1;
      if (bus.ex_branch_taken) begin
        // Branch wins over load-use: the dependent instruction is squashed anyway.
        w_branch_fire = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_id_ex_flush = 1'b1;
      end
    end
  end

  assign w_stall_cnt_en = ((r_state == S_RUN) || (r_state == S_MEMWAIT)) && !w_pc_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (r_state == S_INIT) r_init_cnt  <= r_init_cnt + 1'b1;
      if (w_timeout_set)     r_timeout   <= 1'b1;
      if (w_stall_cnt_en)    r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch_fire)     r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.id_ex_write  = w_id_ex_write;
  assign bus.ex_mem_write = w_ex_mem_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.mem_timeout  = r_timeout;
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_count  = r_flush_cnt;
endmodule
